hdma_pack_fifo: RTL

- Single-clock, parametrised write-path buffer for the HDMA frame-buffer engine.
- Packs PIX_W-bit video pixels into DDR_W-bit DDR words and stores them in an internal synchronous FIFO.
- Raises a burst request when a full DDR burst is buffered.
- Flushes cleanly on a frame-load pulse; the flush length is programmable.
- Successor to the fixed 32/128 dual-FIFO controller: generalised in widths, depth and burst size, and adds overflow and underflow reporting.

---
 rtl/hdma_pack_fifo_pkg.sv | 23 ++
 rtl/hdma_pack_fifo_if.sv | 24 ++
 rtl/hdma_sync_fifo.sv | 76 +++++++
 rtl/hdma_pack_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hdma_pack_fifo_pkg.sv
// hdma_pkg: shared constants and helpers for the HDMA pixel packer FIFO.
// Used by hdma_pack_fifo (optional drop counter: HDMA_DROP_CNT_EN).
package hdma_pkg;

  localparam int DDR_W_DEF = 128;

  typedef logic [15:0] flush_cnt_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ppw(input int ddr_w,
                             input int pix_w);
    return ddr_w / pix_w;
  endfunction

endpackage

// File: rtl/hdma_pack_fifo_if.sv
// Pixel-in / DDR-word-out bus of the HDMA packer FIFO.
// master drives pixels and pops, slave is the FIFO.
interface hdma_pack_fifo_if
  import hdma_pkg::*;
#(
  parameter int PIX_W = 32,
  parameter int DDR_W = DDR_W_DEF
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             rd_en;
  logic [DDR_W-1:0] rd_data;
  logic             rd_valid;

  modport master (
    output pix_valid, pix_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  pix_valid, pix_data, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/hdma_sync_fifo.sv
// Single-clock RAM FIFO with registered read and synchronous clear.
// Part of hdma_pack_fifo (optional drop counter: HDMA_DROP_CNT_EN).
module hdma_sync_fifo
  import hdma_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [W-1:0]          wdata_i,
  output logic [W-1:0]          rdata_o,
  output logic                  rvalid_o,
  output logic [clog2(DEPTH):0] level_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [W-1:0]  rdata_q;
  logic          rvalid_q;
  logic          push_ok, pop_ok;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  // a full FIFO still takes a word when a pop frees a slot
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    lvl_d = lvl_q;
    unique case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (clr_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      rvalid_q <= pop_ok;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign level_o  = lvl_q;
endmodule

// File: rtl/hdma_pack_fifo.sv
// HDMA write path: packs pixels into DDR words, buffers, flushes on load.
// HDMA_DROP_CNT_EN adds a saturating dropped-word counter output.
module hdma_pack_fifo
  import hdma_pkg::*;
#(
  parameter int PIX_W     = 32,
  parameter int DDR_W     = DDR_W_DEF,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 64,
  parameter int FLUSH_CYC = 16
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic                  load,
  hdma_pack_fifo_if.slave       bus,
  output logic [clog2(DEPTH):0] level,
  output logic                  burst_req,
  output logic                  full,
  output logic                  empty,
  output logic                  flush_busy,
  output logic                  overflow,
  output logic                  underflow
`ifdef HDMA_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);
  localparam int PPW = ppw(DDR_W, PIX_W);
  localparam int CW  = (PPW > 1) ? clog2(PPW) : 1;
  localparam int LW  = clog2(DEPTH) + 1;

  if (!(PIX_W == 8 || PIX_W == 16 || PIX_W == 32)) begin : g_bad_pix
    $error("PIX_W must be 8, 16 or 32");
  end
  if ((DDR_W % PIX_W) != 0) begin : g_bad_ddr
    $error("DDR_W must be a multiple of PIX_W");
  end
  if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 16");
  end
  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst
    $error("BURST_LEN must be in 1..DEPTH");
  end
  if (FLUSH_CYC < 2) begin : g_bad_flush
    $error("FLUSH_CYC must be >= 2");
  end

  logic             load_d_q;
  logic             load_edge;
  flush_cnt_t       fcnt_q, fcnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DDR_W-1:0] pack_q, pack_d;
  logic             push_q, push_d;
  logic             burst_q, burst_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             pop, pop_ok, drop;
  logic             f_full, f_empty, f_rvalid;
  logic [LW-1:0]    f_level;

  assign load_edge  = load & ~load_d_q;
  assign flush_busy = (fcnt_q != '0);
  assign pop        = bus.rd_en & ~flush_busy;
  assign pop_ok     = pop & ~f_empty;
  assign drop       = push_q & f_full & ~pop_ok & ~flush_busy;

  always_comb begin
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    push_d  = 1'b0;
    if (load_edge) fcnt_d = flush_cnt_t'(FLUSH_CYC);
    else if (flush_busy) fcnt_d = fcnt_q - 1'b1;
    // pack_q keeps the finished word while slot 0 of the next one fills
    if (flush_busy) begin
      cnt_d = '0;
    end else if (bus.pix_valid) begin
      pack_d[int'(cnt_q)*PIX_W +: PIX_W] = bus.pix_data;
      if (int'(cnt_q) == PPW - 1) begin
        cnt_d  = '0;
        push_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    burst_d = (f_level >= LW'(BURST_LEN)) && !flush_busy;
    ovf_d   = drop;
    udf_d   = bus.rd_en & f_empty & ~flush_busy;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      load_d_q <= 1'b0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
      pack_q   <= '0;
      push_q   <= 1'b0;
      burst_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      load_d_q <= load;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      push_q   <= push_d;
      burst_q  <= burst_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  hdma_sync_fifo #(
    .W     (DDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_100),
    .rst_n    (rst_n),
    .clr_i    (flush_busy),
    .push_i   (push_q),
    .pop_i    (pop),
    .wdata_i  (pack_q),
    .rdata_o  (bus.rd_data),
    .rvalid_o (f_rvalid),
    .level_o  (f_level),
    .full_o   (f_full),
    .empty_o  (f_empty)
  );

  assign bus.rd_valid = f_rvalid & ~flush_busy;
  assign burst_req    = burst_q & ~flush_busy;
  assign level        = f_level;
  assign full         = f_full;
  assign empty        = f_empty;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef HDMA_DROP_CNT_EN
  logic [15:0] dcnt_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) dcnt_q <= '0;
    else if (load_edge) dcnt_q <= '0;
    else if (drop && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 1'b1;
  end

  assign drop_cnt = dcnt_q;
`endif
endmodule
